// File: rtl/analog_seq_pkg.sv
// Shared types and sizing helpers for the analog status sequencer.
package analog_seq_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, SELECT, REQ} seq_state_t;

  localparam int TIMEOUT_W = 16;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/analog_seq_ch_select.sv
// Round-robin pick: first channel pending this sweep, searching upward from ptr with wrap.
module analog_seq_ch_select
  import analog_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] served,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  localparam logic [IDX_W:0] NUM_CH_V = (IDX_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] pending;

  assign pending = mask & ~served;

  // Scan from the farthest offset down so the nearest pending channel is the last write.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= NUM_CH_V) sum = sum - NUM_CH_V;
      cand = sum[IDX_W-1:0];
      if (pending[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/analog_status_sequencer.sv
// Periodic round-robin sweep of NUM_CH status channels over a shared req/ack measurement port,
// capturing each result into a per-channel status word.
module analog_status_sequencer
  import analog_seq_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 32,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk_in,
  input  logic                       reset_n,
  input  logic                       enable_in,
  input  logic [PERIOD_W-1:0]        period_in,
  input  logic [NUM_CH-1:0]          ch_mask_in,
  input  logic                       irq_clear_in,
  output logic                       meas_req_out,
  output logic [$clog2(NUM_CH)-1:0]  meas_ch_out,
  input  logic                       meas_ack_in,
  input  logic [DATA_W-1:0]          meas_data_in,
  output logic [NUM_CH*DATA_W-1:0]   status_out,
  output logic [NUM_CH-1:0]          status_valid_out,
  output logic                       timeout_irq_out,
  output logic                       busy_out
);

  localparam int IDX_W = ch_idx_w(NUM_CH);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]     LAST_CH = IDX_W'(NUM_CH - 1);

  seq_state_t           state;
  logic [PERIOD_W-1:0]  period_cnt;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic [NUM_CH-1:0]    sweep_mask;
  logic [NUM_CH-1:0]    served;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [IDX_W-1:0]     next_ptr;
  logic                 req_done;

  analog_seq_ch_select #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_ch_select (
    .mask   (sweep_mask),
    .served (served),
    .ptr    (rr_ptr),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign next_ptr = (meas_ch_out == LAST_CH) ? '0 : meas_ch_out + 1'b1;
  // An ack on the final timeout cycle still closes the request as a capture.
  assign req_done = meas_ack_in || (timeout_cnt == TO_LAST);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      period_cnt       <= '0;
      timeout_cnt      <= '0;
      sweep_mask       <= '0;
      served           <= '0;
      rr_ptr           <= '0;
      meas_req_out     <= 1'b0;
      meas_ch_out      <= '0;
      status_out       <= '0;
      status_valid_out <= '0;
      timeout_irq_out  <= 1'b0;
      busy_out         <= 1'b0;
    end else begin
      if (irq_clear_in) timeout_irq_out <= 1'b0;
      case (state)
        IDLE: begin
          period_cnt <= '0;
          if (enable_in) state <= WAIT;
        end
        WAIT: begin
          if (!enable_in) begin
            state      <= IDLE;
            period_cnt <= '0;
          end else if (period_cnt == period_in) begin
            // Sweep start: freeze the mask and forget last sweep's service history.
            state      <= SELECT;
            busy_out   <= 1'b1;
            period_cnt <= '0;
            sweep_mask <= ch_mask_in;
            served     <= '0;
          end else begin
            period_cnt <= period_cnt + 1'b1;
          end
        end
        SELECT: begin
          if (!enable_in) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end else if (pick_found) begin
            state            <= REQ;
            meas_req_out     <= 1'b1;
            meas_ch_out      <= pick_idx;
            served[pick_idx] <= 1'b1;
            timeout_cnt      <= '0;
          end else begin
            state    <= WAIT;
            busy_out <= 1'b0;
          end
        end
        REQ: begin
          if (req_done) begin
            meas_req_out <= 1'b0;
            rr_ptr       <= next_ptr;
            timeout_cnt  <= '0;
            if (meas_ack_in) begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (meas_ch_out == IDX_W'(i)) begin
                  status_out[i*DATA_W +: DATA_W] <= meas_data_in;
                  status_valid_out[i]            <= 1'b1;
                end
              end
            end else begin
              timeout_irq_out <= 1'b1;
            end
            if (enable_in) begin
              state <= SELECT;
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
            end
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
